ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  EX stage plus EX/MEM pipeline register, directly downstream of the ID/EX register.
//  Per instruction: forward rs1/rs2, decode ALUOp/funct, compute add/sub/and/or/addi/lw/sw/beq.
//  Registers the result and MEM/WB control into EX/MEM.
//  MUL runs on an iterative shift-add unit and stalls the front end via ex_stall.
// PARAMETERS
//  XLEN      32  datapath width
//  MUL_BITS  1   multiplier bits consumed per cycle; XLEN % MUL_BITS == 0; MUL_CYCLES = XLEN/MUL_BITS
// PORTS
//  clk             in   1     rising-edge clock
//  reset           in   1     asynchronous, active-high; clears all state and outputs
//  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in   in  1 each   ID/EX control
//  ALUOp_in        in   2     00 add, 01 sub, 10 R-type (funct), 11 I-type addi
//  funct_in        in   10    {funct7, funct3}
//  data1_in, data2_in, imm_in   in  XLEN   ID/EX register data and sign-extended immediate
//  rs1_in, rs2_in, rd_in        in  5      ID/EX register numbers
//  MEM_WB_RegWrite in   1     WB-stage write enable
//  MEM_WB_Rd       in   5     WB-stage destination
//  MEM_WB_Data     in   XLEN  WB-stage write-back value
//  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out   out  1 each   EX/MEM control
//  ALU_result_out  out  XLEN  EX/MEM ALU result or product
//  write_data_out  out  XLEN  EX/MEM store data (forwarded rs2)
//  Rd_out          out  5     EX/MEM destination
//  ex_stall        out  1     high: PC, IF/ID and ID/EX must hold their contents
// BEHAVIOUR
//  Reset (async): every output 0, FSM=IDLE, counter/accumulators 0; ex_stall=0 immediately.
//  Forwarding, operand A (operand B identical with rs2_in):
//  - EX/MEM first: RegWrite_out & !MemtoReg_out & Rd_out!=0 & Rd_out==rs1_in -> ALU_result_out.
//  - Else MEM/WB: MEM_WB_RegWrite & MEM_WB_Rd!=0 & MEM_WB_Rd==rs1_in -> MEM_WB_Data.
//  - Else data1_in.
//  - Load-use is excluded here; the hazard unit stalls for it.
//  ALU input B = ALUSrc_in ? imm_in : forwarded rs2; write_data_out is always forwarded rs2.
//  ALU decode:
//  - ALUOp 00 -> add; 01 -> sub; 11 -> add.
//  - ALUOp 10: funct 0000000_000 add, 0100000_000 sub, 0000000_111 and, 0000000_110 or, 0000001_000 mul.
//  - Any other funct -> add.
//  - Arithmetic is modulo 2^XLEN; mul returns the low XLEN bits; signedness is irrelevant.
//  Non-mul: combinational; EX/MEM latches on the next rising edge (1-cycle latency).
//  FSM states IDLE, BUSY, DONE:
//  - IDLE + is_mul: ex_stall=1 combinationally. Edge -> BUSY; latch forwarded operands into
//    multiplicand/multiplier; acc=0; cnt=MUL_CYCLES-1; EX/MEM <= bubble (all control 0, data 0).
//  - BUSY: ex_stall=1; each edge acc += multiplicand*multiplier[MUL_BITS-1:0], shift both,
//    EX/MEM <= bubble; at cnt==0 go to DONE, else cnt-=1.
//  - DONE: ex_stall=0; edge latches acc and the mul's control/Rd into EX/MEM; -> IDLE.
//  - Mul occupancy of EX: MUL_CYCLES+2 cycles; ex_stall high for MUL_CYCLES+1 cycles.
//  - Operands are captured at IDLE exit; MEM/WB changes during BUSY are ignored.
//  - In DONE the ID/EX inputs still hold the mul; it is not re-detected, so back-to-back muls
//    each take the full sequence.
//  - A mul with RegWrite_in=0 is a bubble and not started.
//  Reset mid-multiply aborts: IDLE, ex_stall=0, result discarded.
// TESTING
//  1. add x3: data1=5, data2=7, ALUOp=10, funct=0 -> next edge ALU_result_out=12, Rd_out=3,
//     RegWrite_out=1, ex_stall=0.
//  2. EX/MEM Rd=5 result 0x10, MEM_WB_Rd=5 data 0x20, new add rs1=5 -> operand A=0x10
//     (EX priority); with EX/MEM RegWrite=0 -> 0x20.
//  3. rs1=0 with EX/MEM and MEM/WB both Rd=0 -> no forward, operand A=data1_in.
//  4. sw: ALUSrc=1, imm=8, data1=0x100, rs2 matches MEM/WB data 0xAB -> ALU_result_out=0x108,
//     write_data_out=0xAB, MemWrite_out=1.
//  5. mul 7 * 0xFFFFFFFD, MUL_BITS=1 -> ex_stall high 33 cycles, 33 bubbles,
//     then ALU_result_out=0xFFFFFFEB, RegWrite_out=1; repeat with MUL_BITS=4 -> stall 9 cycles.
//  6. reset asserted mid-edge at BUSY cycle 10 -> all outputs 0 and ex_stall 0 without a clock;
//     after release, add 1+1 -> 2.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bus between ID/EX (and MEM/WB bypass) and the EX stage with its EX/MEM register.
// The master side drives ID/EX and MEM/WB values and observes the EX/MEM outputs and stall.
interface ex_stage_if #(
   parameter int XLEN = 32
);
   logic            RegWrite_in;
   logic            MemtoReg_in;
   logic            MemRead_in;
   logic            MemWrite_in;
   logic            ALUSrc_in;
   logic [1:0]      ALUOp_in;
   logic [9:0]      funct_in;
   logic [XLEN-1:0] data1_in;
   logic [XLEN-1:0] data2_in;
   logic [XLEN-1:0] imm_in;
   logic [4:0]      rs1_in;
   logic [4:0]      rs2_in;
   logic [4:0]      rd_in;

   logic            MEM_WB_RegWrite;
   logic [4:0]      MEM_WB_Rd;
   logic [XLEN-1:0] MEM_WB_Data;

   logic            RegWrite_out;
   logic            MemtoReg_out;
   logic            MemRead_out;
   logic            MemWrite_out;
   logic [XLEN-1:0] ALU_result_out;
   logic [XLEN-1:0] write_data_out;
   logic [4:0]      Rd_out;
   logic            ex_stall;

   modport master (
      output RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in,
      output ALUOp_in, funct_in, data1_in, data2_in, imm_in,
      output rs1_in, rs2_in, rd_in,
      output MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Data,
      input  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
      input  ALU_result_out, write_data_out, Rd_out, ex_stall
   );

   modport slave (
      input  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in,
      input  ALUOp_in, funct_in, data1_in, data2_in, imm_in,
      input  rs1_in, rs2_in, rd_in,
      input  MEM_WB_RegWrite, MEM_WB_Rd, MEM_WB_Data,
      output RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
      output ALU_result_out, write_data_out, Rd_out, ex_stall
   );
endinterface

// File: rtl/ex_stage.sv
// EX stage with operand forwarding, ALU decode and EX/MEM register; MUL uses an
// iterative shift-add unit that holds the front end through ex_stall.
module ex_stage #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input logic         clk,
   input logic         reset,
   ex_stage_if.slave   bus
);
   localparam int MUL_CYCLES = XLEN / MUL_BITS;
   localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

   localparam logic [9:0] FN_ADD = 10'b0000000_000;
   localparam logic [9:0] FN_SUB = 10'b0100000_000;
   localparam logic [9:0] FN_AND = 10'b0000000_111;
   localparam logic [9:0] FN_OR  = 10'b0000000_110;
   localparam logic [9:0] FN_MUL = 10'b0000001_000;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t            r_state;
   logic              r_regWrite;
   logic              r_memtoReg;
   logic              r_memRead;
   logic              r_memWrite;
   logic [XLEN-1:0]   r_aluResult;
   logic [XLEN-1:0]   r_writeData;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_mcand;
   logic [XLEN-1:0]   r_mplier;
   logic [XLEN-1:0]   r_acc;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_exHitA;
   logic              w_exHitB;
   logic              w_wbHitA;
   logic              w_wbHitB;
   logic [XLEN-1:0]   w_opA;
   logic [XLEN-1:0]   w_fwdB;
   logic [XLEN-1:0]   w_opB;
   logic [XLEN-1:0]   w_aluResult;
   logic              w_isMulFunct;
   logic              w_isMul;
   logic [XLEN-1:0]   w_partial;

   // Loads in EX/MEM are not bypassed; the hazard unit stalls for load-use instead.
   assign w_exHitA = r_regWrite & ~r_memtoReg & (r_rd != 5'd0) & (r_rd == bus.rs1_in);
   assign w_exHitB = r_regWrite & ~r_memtoReg & (r_rd != 5'd0) & (r_rd == bus.rs2_in);
   assign w_wbHitA = bus.MEM_WB_RegWrite & (bus.MEM_WB_Rd != 5'd0) & (bus.MEM_WB_Rd == bus.rs1_in);
   assign w_wbHitB = bus.MEM_WB_RegWrite & (bus.MEM_WB_Rd != 5'd0) & (bus.MEM_WB_Rd == bus.rs2_in);

   assign w_opA  = w_exHitA ? r_aluResult : (w_wbHitA ? bus.MEM_WB_Data : bus.data1_in);
   assign w_fwdB = w_exHitB ? r_aluResult : (w_wbHitB ? bus.MEM_WB_Data : bus.data2_in);
   assign w_opB  = bus.ALUSrc_in ? bus.imm_in : w_fwdB;

   always_comb begin
      w_aluResult  = w_opA + w_opB;
      w_isMulFunct = 1'b0;
      case (bus.ALUOp_in)
         2'b01: w_aluResult = w_opA - w_opB;
         2'b10: begin
            case (bus.funct_in)
               FN_ADD:  w_aluResult = w_opA + w_opB;
               FN_SUB:  w_aluResult = w_opA - w_opB;
               FN_AND:  w_aluResult = w_opA & w_opB;
               FN_OR:   w_aluResult = w_opA | w_opB;
               FN_MUL:  w_isMulFunct = 1'b1;
               default: w_aluResult = w_opA + w_opB;
            endcase
         end
         default: w_aluResult = w_opA + w_opB;
      endcase
   end

   assign w_isMul   = w_isMulFunct & bus.RegWrite_in;
   assign w_partial = r_mcand * XLEN'(r_mplier[MUL_BITS-1:0]);

   // DONE is excluded so the mul still sitting in ID/EX is not started a second time.
   assign bus.ex_stall = ~reset & ((r_state == BUSY) | ((r_state == IDLE) & w_isMul));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_regWrite  <= 1'b0;
         r_memtoReg  <= 1'b0;
         r_memRead   <= 1'b0;
         r_memWrite  <= 1'b0;
         r_aluResult <= '0;
         r_writeData <= '0;
         r_rd        <= 5'd0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
      end else begin
         r_regWrite  <= 1'b0;
         r_memtoReg  <= 1'b0;
         r_memRead   <= 1'b0;
         r_memWrite  <= 1'b0;
         r_aluResult <= '0;
         r_writeData <= '0;
         r_rd        <= 5'd0;
         case (r_state)
            IDLE: begin
               if (w_isMul) begin
                  r_state  <= BUSY;
                  r_mcand  <= w_opA;
                  r_mplier <= w_fwdB;
                  r_acc    <= '0;
                  r_cnt    <= CNT_W'(MUL_CYCLES - 1);
               end else if (!w_isMulFunct) begin
                  r_regWrite  <= bus.RegWrite_in;
                  r_memtoReg  <= bus.MemtoReg_in;
                  r_memRead   <= bus.MemRead_in;
                  r_memWrite  <= bus.MemWrite_in;
                  r_aluResult <= w_aluResult;
                  r_writeData <= w_fwdB;
                  r_rd        <= bus.rd_in;
               end
            end
            BUSY: begin
               r_acc    <= r_acc + w_partial;
               r_mcand  <= r_mcand << MUL_BITS;
               r_mplier <= r_mplier >> MUL_BITS;
               if (r_cnt == '0) begin
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               r_state     <= IDLE;
               r_regWrite  <= bus.RegWrite_in;
               r_memtoReg  <= bus.MemtoReg_in;
               r_memRead   <= bus.MemRead_in;
               r_memWrite  <= bus.MemWrite_in;
               r_aluResult <= r_acc;
               r_rd        <= bus.rd_in;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.RegWrite_out   = r_regWrite;
   assign bus.MemtoReg_out   = r_memtoReg;
   assign bus.MemRead_out    = r_memRead;
   assign bus.MemWrite_out   = r_memWrite;
   assign bus.ALU_result_out = r_aluResult;
   assign bus.write_data_out = r_writeData;
   assign bus.Rd_out         = r_rd;
endmodule
